wca_cordic12_rotator: RTL and testbench

- Pipelined 12-bit CORDIC vector rotator in rotation mode, advanced by a data strobe.
- Rotates the input vector (X0,Y0) by angle A0. Returns the rotated vector scaled by the CORDIC gain (K≈1.6468), plus the residual angle.
- Used in the down-converter front end: a phase generator supplies A0 and a quadrant pre-rotator limits A0 to ±pi/2.

---
 rtl/cordic12_pkg.sv | 25 ++
 rtl/cordic12_stage.sv | 67 ++++++
 rtl/wca_cordic12_rotator.sv | 134 +++++++++++++
 tb/tb_wca_cordic12_rotator.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic12_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic12_pkg
//  Description : Shared constants and helpers for the 12-bit CORDIC rotator:
//                arctangent table, iteration count, internal width and the
//                gain-compensation factor.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic12_pkg;

    localparam int c_iterations = 11;

    // atan(2^-i) with 1024 = pi/2
    localparam int c_atan_table [c_iterations] = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1};

    // 1/K ~= 1243 / 2^11
    localparam int c_gain_comp_mul   = 1243;
    localparam int c_gain_comp_shift = 11;

    function automatic int internal_width(input int data_width, input int extra_guard);
        return data_width + 2 + extra_guard;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic12_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cordic12_stage
//  Description : One strobed CORDIC micro-rotation (rotation mode) for
//                iteration IDX.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic12_stage
    import cordic12_pkg::*;
#(
    parameter int IDX         = 0,
    parameter int WIDTH       = 14,
    parameter int ANGLE_WIDTH = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ngreset,
    input  logic                          i_strobe,
    input  logic signed [WIDTH-1:0]       i_x,
    input  logic signed [WIDTH-1:0]       i_y,
    input  logic signed [ANGLE_WIDTH-1:0] i_z,
    output logic signed [WIDTH-1:0]       o_x,
    output logic signed [WIDTH-1:0]       o_y,
    output logic signed [ANGLE_WIDTH-1:0] o_z
);

    localparam logic signed [ANGLE_WIDTH-1:0] c_atan = ANGLE_WIDTH'(c_atan_table[IDX]);

    logic signed [WIDTH-1:0]       w_x_sh;
    logic signed [WIDTH-1:0]       w_y_sh;
    logic                          w_z_nonneg;
    logic signed [WIDTH-1:0]       r_x;
    logic signed [WIDTH-1:0]       r_y;
    logic signed [ANGLE_WIDTH-1:0] r_z;

    assign w_x_sh     = i_x >>> IDX;
    assign w_y_sh     = i_y >>> IDX;
    assign w_z_nonneg = ~i_z[ANGLE_WIDTH-1];

    always_ff @(posedge clock or negedge ngreset) begin
        if (!ngreset) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (reset) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (i_strobe) begin
            if (w_z_nonneg) begin
                r_x <= i_x - w_y_sh;
                r_y <= i_y + w_x_sh;
                r_z <= i_z - c_atan;
            end else begin
                r_x <= i_x + w_y_sh;
                r_y <= i_y - w_x_sh;
                r_z <= i_z + c_atan;
            end
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;
    assign o_z = r_z;

endmodule
`default_nettype wire

// File: rtl/wca_cordic12_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : wca_cordic12_rotator
//  Description : Strobed, pipelined 12-bit CORDIC vector rotator. Optional
//                1/K gain compensation stage via CORDIC12_GAIN_COMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module wca_cordic12_rotator
    import cordic12_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int ANGLE_WIDTH = 12,
    parameter int EXTRA_GUARD = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ngreset,
    input  logic                   strobeData,
    input  logic [DATA_WIDTH-1:0]  X0,
    input  logic [DATA_WIDTH-1:0]  Y0,
    input  logic [ANGLE_WIDTH-1:0] A0,
    output logic [DATA_WIDTH-1:0]  XN,
    output logic [DATA_WIDTH-1:0]  YN,
    output logic [ANGLE_WIDTH-1:0] AN
);

    localparam int c_w = internal_width(DATA_WIDTH, EXTRA_GUARD);
    localparam logic signed [c_w-1:0] c_sat_max = c_w'((1 <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [c_w-1:0] c_sat_min = -c_sat_max - c_w'(1);

    logic signed [c_w-1:0]         r_x0;
    logic signed [c_w-1:0]         r_y0;
    logic signed [ANGLE_WIDTH-1:0] r_a0;

    // Element 0 is the input register, element k+1 the output of iteration k
    logic signed [c_w-1:0]         w_x [0:c_iterations];
    logic signed [c_w-1:0]         w_y [0:c_iterations];
    logic signed [ANGLE_WIDTH-1:0] w_z [0:c_iterations];

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [c_w-1:0] v);
        if (v > c_sat_max) begin
            return c_sat_max[DATA_WIDTH-1:0];
        end else if (v < c_sat_min) begin
            return c_sat_min[DATA_WIDTH-1:0];
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clock or negedge ngreset) begin
        if (!ngreset) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_a0 <= '0;
        end else if (reset) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_a0 <= '0;
        end else if (strobeData) begin
            r_x0 <= $signed({{(c_w - DATA_WIDTH){X0[DATA_WIDTH-1]}}, X0});
            r_y0 <= $signed({{(c_w - DATA_WIDTH){Y0[DATA_WIDTH-1]}}, Y0});
            r_a0 <= $signed(A0);
        end
    end

    assign w_x[0] = r_x0;
    assign w_y[0] = r_y0;
    assign w_z[0] = r_a0;

    for (genvar k = 0; k < c_iterations; k++) begin : g_stage
        cordic12_stage #(
            .IDX         (k),
            .WIDTH       (c_w),
            .ANGLE_WIDTH (ANGLE_WIDTH)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .ngreset  (ngreset),
            .i_strobe (strobeData),
            .i_x      (w_x[k]),
            .i_y      (w_y[k]),
            .i_z      (w_z[k]),
            .o_x      (w_x[k+1]),
            .o_y      (w_y[k+1]),
            .o_z      (w_z[k+1])
        );
    end

`ifdef CORDIC12_GAIN_COMP_EN
    localparam int c_pw = c_w + 12;
    localparam logic signed [c_pw-1:0] c_comp_mul  = c_pw'(c_gain_comp_mul);
    localparam logic signed [c_pw-1:0] c_comp_half = c_pw'(1 <<< (c_gain_comp_shift - 1));

    logic signed [c_pw-1:0]        w_x_prod;
    logic signed [c_pw-1:0]        w_y_prod;
    logic signed [c_w-1:0]         w_x_comp;
    logic signed [c_w-1:0]         w_y_comp;
    logic [DATA_WIDTH-1:0]         r_xn;
    logic [DATA_WIDTH-1:0]         r_yn;
    logic [ANGLE_WIDTH-1:0]        r_an;

    assign w_x_prod = $signed({{12{w_x[c_iterations][c_w-1]}}, w_x[c_iterations]}) * c_comp_mul;
    assign w_y_prod = $signed({{12{w_y[c_iterations][c_w-1]}}, w_y[c_iterations]}) * c_comp_mul;
    // Round half up, then drop the fractional bits of the 1/K product
    assign w_x_comp = c_w'((w_x_prod + c_comp_half) >>> c_gain_comp_shift);
    assign w_y_comp = c_w'((w_y_prod + c_comp_half) >>> c_gain_comp_shift);

    always_ff @(posedge clock or negedge ngreset) begin
        if (!ngreset) begin
            r_xn <= '0;
            r_yn <= '0;
            r_an <= '0;
        end else if (reset) begin
            r_xn <= '0;
            r_yn <= '0;
            r_an <= '0;
        end else if (strobeData) begin
            r_xn <= saturate(w_x_comp);
            r_yn <= saturate(w_y_comp);
            r_an <= w_z[c_iterations];
        end
    end

    assign XN = r_xn;
    assign YN = r_yn;
    assign AN = r_an;
`else
    // The last iteration register is the output register; saturation is pure logic after it
    assign XN = saturate(w_x[c_iterations]);
    assign YN = saturate(w_y[c_iterations]);
    assign AN = w_z[c_iterations];
`endif

endmodule
`default_nettype wire

// File: tb/tb_wca_cordic12_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wca_cordic12_rotator
//  Description : Scoreboard bench for wca_cordic12_rotator (honours
//                CORDIC12_GAIN_COMP_EN for latency and expected values).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wca_cordic12_rotator;

`ifdef CORDIC12_GAIN_COMP_EN
    localparam int c_lat      = 13;
    localparam int c_zero_ref = 1000;
`else
    localparam int c_lat      = 12;
    localparam int c_zero_ref = 1647;
`endif
    localparam int c_atan [11] = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1};

    typedef struct {
        logic [11:0] xn;
        logic [11:0] yn;
        logic [11:0] an;
        bit          chk;
        int          tag;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        ngreset;
    logic        strobeData;
    logic [11:0] X0;
    logic [11:0] Y0;
    logic [11:0] A0;
    logic [11:0] XN;
    logic [11:0] YN;
    logic [11:0] AN;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wca_cordic12_rotator #(
        .DATA_WIDTH  (12),
        .ANGLE_WIDTH (12),
        .EXTRA_GUARD (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ngreset    (ngreset),
        .strobeData (strobeData),
        .X0         (X0),
        .Y0         (Y0),
        .A0         (A0),
        .XN         (XN),
        .YN         (YN),
        .AN         (AN)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic exp_t model(input int x0, input int y0, input int a0, input int tag);
        int   x = x0;
        int   y = y0;
        int   z = a0;
        int   dx;
        int   dy;
        exp_t r;
        for (int i = 0; i < 11; i++) begin
            dx = y >>> i;
            dy = x >>> i;
            if (z >= 0) begin
                x = x - dx; y = y + dy; z = z - c_atan[i];
            end else begin
                x = x + dx; y = y - dy; z = z + c_atan[i];
            end
        end
`ifdef CORDIC12_GAIN_COMP_EN
        x = (x * 1243 + 1024) >>> 11;
        y = (y * 1243 + 1024) >>> 11;
`endif
        r.xn  = 12'(sat12(x));
        r.yn  = 12'(sat12(y));
        r.an  = 12'(z);
        r.chk = 1'b1;
        r.tag = tag;
        return r;
    endfunction

    function automatic int rnd1024();
        return int'($urandom_range(2048)) - 1024;
    endfunction

    // After any reset the first c_lat-1 strobed outputs come from flushed registers
    task automatic sb_reset();
        exp_t d;
        d = '{xn: 12'd0, yn: 12'd0, an: 12'd0, chk: 1'b0, tag: 0};
        sb.delete();
        for (int k = 0; k < c_lat - 1; k++) sb.push_back(d);
    endtask

    task automatic step(input bit strb, input int x, input int y, input int a, input int tag,
                        output bit popped, output exp_t e);
        strobeData = strb;
        X0 = x[11:0];
        Y0 = y[11:0];
        A0 = a[11:0];
        @(posedge clock);
        #1;
        popped = 1'b0;
        e = '{xn: 12'd0, yn: 12'd0, an: 12'd0, chk: 1'b0, tag: 0};
        if (strb) begin
            sb.push_back(model(x, y, a, tag));
            if (sb.size() >= c_lat) begin
                e = sb.pop_front();
                popped = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; strobeData = 1'b1;
        X0 = 12'd700; Y0 = 12'd300; A0 = 12'd200;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if (XN !== 12'd0 || YN !== 12'd0 || AN !== 12'd0) begin
                n_fail++;
                $display("FAIL reset: XN/YN/AN=%0d/%0d/%0d required 0/0/0", XN, YN, AN);
            end
        end
        reset = 1'b0;
        sb_reset();
    endtask

    task automatic test_zero_angle();
        bit   p;
        exp_t e;
        for (int k = 0; k < c_lat; k++) begin
            step(1'b1, (k == 0) ? 1000 : 0, 0, 0, (k == 0) ? 1 : 0, p, e);
            if (p && e.chk) begin
                n_tests++;
                if (XN !== e.xn || YN !== e.yn || AN !== e.an) begin
                    n_fail++;
                    $display("FAIL zero_angle: XN/YN/AN=%0d/%0d/%0d required %0d/%0d/%0d",
                             $signed(XN), $signed(YN), $signed(AN), $signed(e.xn), $signed(e.yn), $signed(e.an));
                end
                if (e.tag == 1) begin
                    n_tests++;
                    if ($signed(XN) > c_zero_ref + 3 || $signed(XN) < c_zero_ref - 3 ||
                        $signed(YN) > 3 || $signed(YN) < -3) begin
                        n_fail++;
                        $display("FAIL zero_angle_abs: XN/YN=%0d/%0d required %0d/0 +-3",
                                 $signed(XN), $signed(YN), c_zero_ref);
                    end
                end
            end
        end
    endtask

    task automatic test_angles();
        int   vx[8] = '{1000, 1000, 1000, 1000, 0, 1024, -1024, 700};
        int   vy[8] = '{0, 0, 0, 0, 1000, 1024, -1024, -900};
        int   va[8] = '{512, 1024, -1024, -512, 300, 512, -512, -1000};
        bit   p;
        exp_t e;
        for (int k = 0; k < 8 + c_lat; k++) begin
            if (k < 8) step(1'b1, vx[k], vy[k], va[k], 0, p, e);
            else       step(1'b1, 0, 0, 0, 0, p, e);
            if (p && e.chk) begin
                n_tests++;
                if (XN !== e.xn || YN !== e.yn || AN !== e.an) begin
                    n_fail++;
                    $display("FAIL angles: XN/YN/AN=%0d/%0d/%0d required %0d/%0d/%0d",
                             $signed(XN), $signed(YN), $signed(AN), $signed(e.xn), $signed(e.yn), $signed(e.an));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit   p;
        exp_t e;
        for (int k = 0; k < 40 + c_lat; k++) begin
            if (k < 40) step(1'b1, rnd1024(), rnd1024(), rnd1024(), 0, p, e);
            else        step(1'b1, 0, 0, 0, 0, p, e);
            if (p && e.chk) begin
                n_tests++;
                if (XN !== e.xn || YN !== e.yn || AN !== e.an) begin
                    n_fail++;
                    $display("FAIL back_to_back: XN/YN/AN=%0d/%0d/%0d required %0d/%0d/%0d",
                             $signed(XN), $signed(YN), $signed(AN), $signed(e.xn), $signed(e.yn), $signed(e.an));
                end
            end
        end
    endtask

    task automatic test_strobe_gating();
        bit   p;
        exp_t e;
        exp_t last;
        last = '{xn: 12'd0, yn: 12'd0, an: 12'd0, chk: 1'b0, tag: 0};
        for (int s = 0; s < 2 * c_lat; s++) begin
            step(1'b1, (s == 3) ? 900 : 0, (s == 3) ? -400 : 0, (s == 3) ? 700 : 0, 0, p, e);
            if (p && e.chk) begin
                last = e;
                n_tests++;
                if (XN !== e.xn || YN !== e.yn || AN !== e.an) begin
                    n_fail++;
                    $display("FAIL gating: XN/YN/AN=%0d/%0d/%0d required %0d/%0d/%0d",
                             $signed(XN), $signed(YN), $signed(AN), $signed(e.xn), $signed(e.yn), $signed(e.an));
                end
            end
            for (int g = 0; g < 3; g++) begin
                step(1'b0, rnd1024(), rnd1024(), rnd1024(), 0, p, e);
                if (last.chk) begin
                    n_tests++;
                    if (XN !== last.xn || YN !== last.yn || AN !== last.an) begin
                        n_fail++;
                        $display("FAIL gating_hold: XN/YN/AN=%0d/%0d/%0d required %0d/%0d/%0d",
                                 $signed(XN), $signed(YN), $signed(AN), $signed(last.xn), $signed(last.yn), $signed(last.an));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit   p;
        exp_t e;
        for (int k = 0; k < 15; k++) step(1'b1, rnd1024(), rnd1024(), rnd1024(), 0, p, e);
        reset = 1'b1;
        strobeData = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_tests++;
        if (XN !== 12'd0 || YN !== 12'd0 || AN !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_mid: XN/YN/AN=%0d/%0d/%0d required 0/0/0", XN, YN, AN);
        end
        sb_reset();
        for (int k = 0; k < 6 + c_lat; k++) begin
            if (k < 6) step(1'b1, rnd1024(), rnd1024(), rnd1024(), 0, p, e);
            else       step(1'b1, 0, 0, 0, 0, p, e);
            if (p && e.chk) begin
                n_tests++;
                if (XN !== e.xn || YN !== e.yn || AN !== e.an) begin
                    n_fail++;
                    $display("FAIL reset_mid_refill: XN/YN/AN=%0d/%0d/%0d required %0d/%0d/%0d",
                             $signed(XN), $signed(YN), $signed(AN), $signed(e.xn), $signed(e.yn), $signed(e.an));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit   p;
        exp_t e;
        for (int k = 0; k < 14; k++) step(1'b1, rnd1024(), rnd1024(), rnd1024(), 0, p, e);
        #2;
        ngreset = 1'b0;
        #1;
        n_tests++;
        if (XN !== 12'd0 || YN !== 12'd0 || AN !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset: XN/YN/AN=%0d/%0d/%0d required 0/0/0", XN, YN, AN);
        end
        strobeData = 1'b1;
        @(posedge clock);
        #1;
        n_tests++;
        if (XN !== 12'd0 || YN !== 12'd0 || AN !== 12'd0) begin
            n_fail++;
            $display("FAIL async_reset_hold: XN/YN/AN=%0d/%0d/%0d required 0/0/0", XN, YN, AN);
        end
        ngreset = 1'b1;
        sb_reset();
        for (int k = 0; k < 3 + c_lat; k++) begin
            if (k < 3) step(1'b1, rnd1024(), rnd1024(), rnd1024(), 0, p, e);
            else       step(1'b1, 0, 0, 0, 0, p, e);
            if (p && e.chk) begin
                n_tests++;
                if (XN !== e.xn || YN !== e.yn || AN !== e.an) begin
                    n_fail++;
                    $display("FAIL async_refill: XN/YN/AN=%0d/%0d/%0d required %0d/%0d/%0d",
                             $signed(XN), $signed(YN), $signed(AN), $signed(e.xn), $signed(e.yn), $signed(e.an));
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        ngreset    = 1'b1;
        strobeData = 1'b0;
        X0         = '0;
        Y0         = '0;
        A0         = '0;
        test_reset();
        test_zero_angle();
        test_angles();
        test_back_to_back();
        test_strobe_gating();
        test_reset_midstream();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
